// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - two-requester / shared-memory signal bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [DATA_W-1:0] m0_wr_data_i, m1_wr_data_i;
    logic [ADDR_W-1:0] m0_wr_addr_i, m1_wr_addr_i;
    logic              m0_wr_vld_i,  m1_wr_vld_i;
    logic              m0_wr_rdy_o,  m1_wr_rdy_o;
    logic [ADDR_W-1:0] m0_rd_addr_i, m1_rd_addr_i;
    logic              m0_rd_vld_i,  m1_rd_vld_i;
    logic              m0_rd_rdy_o,  m1_rd_rdy_o;
    logic [DATA_W-1:0] m0_rd_data_o, m1_rd_data_o;
    logic              m0_rd_dvld_o, m1_rd_dvld_o;
    logic [DATA_W-1:0] mem_wr_data_o;
    logic [ADDR_W-1:0] mem_wr_addr_o;
    logic              mem_wr_vld_o;
    logic              mem_wr_rdy_i;
    logic [ADDR_W-1:0] mem_rd_addr_o;
    logic              mem_rd_vld_o;
    logic [DATA_W-1:0] mem_rd_data_i;
    logic              mem_rd_rdy_i;

    modport slave (
        input  m0_wr_data_i, m1_wr_data_i, m0_wr_addr_i, m1_wr_addr_i,
        input  m0_wr_vld_i, m1_wr_vld_i, m0_rd_addr_i, m1_rd_addr_i,
        input  m0_rd_vld_i, m1_rd_vld_i, mem_wr_rdy_i, mem_rd_data_i, mem_rd_rdy_i,
        output m0_wr_rdy_o, m1_wr_rdy_o, m0_rd_rdy_o, m1_rd_rdy_o,
        output m0_rd_data_o, m1_rd_data_o, m0_rd_dvld_o, m1_rd_dvld_o,
        output mem_wr_data_o, mem_wr_addr_o, mem_wr_vld_o, mem_rd_addr_o, mem_rd_vld_o
    );

    modport master (
        output m0_wr_data_i, m1_wr_data_i, m0_wr_addr_i, m1_wr_addr_i,
        output m0_wr_vld_i, m1_wr_vld_i, m0_rd_addr_i, m1_rd_addr_i,
        output m0_rd_vld_i, m1_rd_vld_i, mem_wr_rdy_i, mem_rd_data_i, mem_rd_rdy_i,
        input  m0_wr_rdy_o, m1_wr_rdy_o, m0_rd_rdy_o, m1_rd_rdy_o,
        input  m0_rd_data_o, m1_rd_data_o, m0_rd_dvld_o, m1_rd_dvld_o,
        input  mem_wr_data_o, mem_wr_addr_o, mem_wr_vld_o, mem_rd_addr_o, mem_rd_vld_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester shared-memory arbiter with independent write/read channels
// MEM_ARBITER_RR_EN selects round-robin tie-breaking; undefined gives fixed priority to requester 0.
module mem_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    logic              wr_any, wr_sel, wr_go;
    logic              rd_any, rd_sel, rd_go;
    logic              tag_vld_q, tag_vld_d;
    logic              tag_id_q, tag_id_d;
    logic              dvld0_q, dvld0_d, dvld1_q, dvld1_d;
    logic [DATA_W-1:0] rd_data0_q, rd_data0_d, rd_data1_q, rd_data1_d;
`ifdef MEM_ARBITER_RR_EN
    logic              wr_last_q, wr_last_d;
    logic              rd_last_q, rd_last_d;
`endif

    always_comb begin
        wr_any = bus.m0_wr_vld_i | bus.m1_wr_vld_i;
        rd_any = bus.m0_rd_vld_i | bus.m1_rd_vld_i;
`ifdef MEM_ARBITER_RR_EN
        // On a tie, requester 1 wins only when requester 0 was the last one granted.
        wr_sel = bus.m1_wr_vld_i & (~bus.m0_wr_vld_i | ~wr_last_q);
        rd_sel = bus.m1_rd_vld_i & (~bus.m0_rd_vld_i | ~rd_last_q);
`else
        wr_sel = bus.m1_wr_vld_i & ~bus.m0_wr_vld_i;
        rd_sel = bus.m1_rd_vld_i & ~bus.m0_rd_vld_i;
`endif
        wr_go = wr_any & bus.mem_wr_rdy_i & ~rst;
        rd_go = rd_any & ~rst;

        bus.m0_wr_rdy_o   = wr_go & ~wr_sel;
        bus.m1_wr_rdy_o   = wr_go & wr_sel;
        bus.mem_wr_vld_o  = wr_any & ~rst;
        bus.mem_wr_addr_o = wr_sel ? bus.m1_wr_addr_i : bus.m0_wr_addr_i;
        bus.mem_wr_data_o = wr_sel ? bus.m1_wr_data_i : bus.m0_wr_data_i;

        bus.m0_rd_rdy_o   = rd_go & ~rd_sel;
        bus.m1_rd_rdy_o   = rd_go & rd_sel;
        bus.mem_rd_vld_o  = rd_go;
        bus.mem_rd_addr_o = rd_sel ? bus.m1_rd_addr_i : bus.m0_rd_addr_i;

        // The tag follows the accepted read into the memory's one-cycle latency slot.
        tag_vld_d  = rd_go;
        tag_id_d   = rd_sel;
        dvld0_d    = tag_vld_q & bus.mem_rd_rdy_i & ~tag_id_q;
        dvld1_d    = tag_vld_q & bus.mem_rd_rdy_i & tag_id_q;
        rd_data0_d = dvld0_d ? bus.mem_rd_data_i : rd_data0_q;
        rd_data1_d = dvld1_d ? bus.mem_rd_data_i : rd_data1_q;
`ifdef MEM_ARBITER_RR_EN
        wr_last_d = wr_go ? wr_sel : wr_last_q;
        rd_last_d = rd_go ? rd_sel : rd_last_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q  <= 1'b0;
            tag_id_q   <= 1'b0;
            dvld0_q    <= 1'b0;
            dvld1_q    <= 1'b0;
            rd_data0_q <= '0;
            rd_data1_q <= '0;
`ifdef MEM_ARBITER_RR_EN
            // "Last granted = 1" makes requester 0 win the first tie.
            wr_last_q  <= 1'b1;
            rd_last_q  <= 1'b1;
`endif
        end else begin
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            dvld0_q    <= dvld0_d;
            dvld1_q    <= dvld1_d;
            rd_data0_q <= rd_data0_d;
            rd_data1_q <= rd_data1_d;
`ifdef MEM_ARBITER_RR_EN
            wr_last_q  <= wr_last_d;
            rd_last_q  <= rd_last_d;
`endif
        end
    end

    assign bus.m0_rd_data_o = rd_data0_q;
    assign bus.m1_rd_data_o = rd_data1_q;
    assign bus.m0_rd_dvld_o = dvld0_q;
    assign bus.m1_rd_dvld_o = dvld1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - table-driven and scoreboard bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;
    localparam int DW = 8;
    localparam int AW = 8;
`ifdef MEM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic       wv0, wv1, rv0, rv1, wrdy;
        logic [7:0] wa0, wd0, wa1, wd1, ra0, ra1;
        logic [3:0] exp_rr;   // {m0_wr, m1_wr, m0_rd, m1_rd} ready
        logic [3:0] exp_fp;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         due;
    } rsp_t;

    rsp_t       sb[$];
    vec_t       vt[7];
    logic [7:0] mem[256];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic       drop_rsp = 1'b0;
    logic       stray_rdy = 1'b0;
    logic       cap_rvld, cap_wen;
    logic [7:0] cap_raddr, cap_waddr, cap_wdata;
    logic [3:0] exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, want);
        end
    endtask

    task automatic idle_inputs();
        bus.m0_wr_vld_i = 1'b0; bus.m1_wr_vld_i = 1'b0;
        bus.m0_rd_vld_i = 1'b0; bus.m1_rd_vld_i = 1'b0;
        bus.m0_wr_addr_i = '0; bus.m1_wr_addr_i = '0;
        bus.m0_wr_data_i = '0; bus.m1_wr_data_i = '0;
        bus.m0_rd_addr_i = '0; bus.m1_rd_addr_i = '0;
        bus.mem_wr_rdy_i = 1'b1;
    endtask

    task automatic expect_read(input int id, input logic [7:0] data);
        rsp_t r;
        r.id = id; r.data = data; r.due = cyc + 2;
        sb.push_back(r);
    endtask

    task automatic check_resp();
        rsp_t r;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            chk("rsp_dvld", {bus.m1_rd_dvld_o, bus.m0_rd_dvld_o}, (r.id == 1) ? 2'b10 : 2'b01);
            chk("rsp_data", (r.id == 1) ? bus.m1_rd_data_o : bus.m0_rd_data_o, r.data);
        end else begin
            chk("rsp_idle", {bus.m1_rd_dvld_o, bus.m0_rd_dvld_o}, 2'b00);
        end
    endtask

    // Called at the negedge; returns at posedge+1 with the memory response driven.
    task automatic end_cycle();
        check_resp();
        cap_rvld  = bus.mem_rd_vld_o;
        cap_raddr = bus.mem_rd_addr_o;
        cap_wen   = bus.mem_wr_vld_o & bus.mem_wr_rdy_i;
        cap_waddr = bus.mem_wr_addr_o;
        cap_wdata = bus.mem_wr_data_o;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) sb.delete();
        if (cap_rvld) begin
            bus.mem_rd_data_i = mem[cap_raddr];
            bus.mem_rd_rdy_i  = ~drop_rsp;
            if (drop_rsp && sb.size() > 0) void'(sb.pop_back());
        end else begin
            bus.mem_rd_data_i = 8'hEE;
            bus.mem_rd_rdy_i  = stray_rdy;
        end
        if (cap_wen) mem[cap_waddr] = cap_wdata;
        drop_rsp  = 1'b0;
        stray_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.m0_wr_vld_i = 1'b1; bus.m1_wr_vld_i = 1'b1;
        bus.m0_rd_vld_i = 1'b1; bus.m1_rd_vld_i = 1'b1;
        bus.mem_wr_rdy_i = 1'b1;
        @(negedge clk);
        chk("rst_rdy_forced", {bus.m0_wr_rdy_o, bus.m1_wr_rdy_o, bus.m0_rd_rdy_o, bus.m1_rd_rdy_o}, 4'b0000);
        chk("rst_mem_vld_forced", {bus.mem_wr_vld_o, bus.mem_rd_vld_o}, 2'b00);
        end_cycle();
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        vt[0] = '{0,0,0,0,1, 8'h00,8'h00,8'h00,8'h00,8'h00,8'h00, 4'b0000, 4'b0000};
        vt[1] = '{1,0,0,1,1, 8'h10,8'hAA,8'h11,8'hBB,8'h50,8'h51, 4'b1001, 4'b1001};
        vt[2] = '{1,1,1,1,1, 8'h12,8'hC1,8'h13,8'hC2,8'h52,8'h53, 4'b0110, 4'b1010};
        vt[3] = '{1,1,1,1,1, 8'h14,8'hC3,8'h15,8'hC4,8'h54,8'h55, 4'b1001, 4'b1010};
        vt[4] = '{0,1,1,0,1, 8'h16,8'hC5,8'h17,8'hC6,8'h56,8'h57, 4'b0110, 4'b0110};
        vt[5] = '{1,1,1,1,0, 8'h18,8'hC7,8'h19,8'hC8,8'h58,8'h59, 4'b0001, 4'b0010};
        vt[6] = '{1,1,0,0,1, 8'h1A,8'hC9,8'h1B,8'hCA,8'h5A,8'h5B, 4'b1000, 4'b1000};

        rst = 1'b1;
        idle_inputs();
        bus.mem_rd_data_i = '0;
        bus.mem_rd_rdy_i  = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        @(negedge clk);
        chk("reset_rd_data", {bus.m0_rd_data_o, bus.m1_rd_data_o}, 16'h0000);
        chk("reset_dvld", {bus.m0_rd_dvld_o, bus.m1_rd_dvld_o}, 2'b00);
        end_cycle();

        // Table of arbitration vectors from a fresh reset.
        for (int i = 0; i < 7; i++) begin
            bus.m0_wr_vld_i = vt[i].wv0; bus.m1_wr_vld_i = vt[i].wv1;
            bus.m0_rd_vld_i = vt[i].rv0; bus.m1_rd_vld_i = vt[i].rv1;
            bus.mem_wr_rdy_i = vt[i].wrdy;
            bus.m0_wr_addr_i = vt[i].wa0; bus.m0_wr_data_i = vt[i].wd0;
            bus.m1_wr_addr_i = vt[i].wa1; bus.m1_wr_data_i = vt[i].wd1;
            bus.m0_rd_addr_i = vt[i].ra0; bus.m1_rd_addr_i = vt[i].ra1;
            @(negedge clk);
            exp = RR ? vt[i].exp_rr : vt[i].exp_fp;
            chk("vec_rdy", {bus.m0_wr_rdy_o, bus.m1_wr_rdy_o, bus.m0_rd_rdy_o, bus.m1_rd_rdy_o}, exp);
            chk("vec_mem_rd_vld", bus.mem_rd_vld_o, vt[i].rv0 | vt[i].rv1);
            if (exp[3]) begin
                chk("vec_wr_addr_m0", bus.mem_wr_addr_o, vt[i].wa0);
                chk("vec_wr_data_m0", bus.mem_wr_data_o, vt[i].wd0);
            end else if (exp[2]) begin
                chk("vec_wr_addr_m1", bus.mem_wr_addr_o, vt[i].wa1);
                chk("vec_wr_data_m1", bus.mem_wr_data_o, vt[i].wd1);
            end
            if (exp[1]) begin
                chk("vec_rd_addr_m0", bus.mem_rd_addr_o, vt[i].ra0);
                expect_read(0, mem[vt[i].ra0]);
            end else if (exp[0]) begin
                chk("vec_rd_addr_m1", bus.mem_rd_addr_o, vt[i].ra1);
                expect_read(1, mem[vt[i].ra1]);
            end
            end_cycle();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin @(negedge clk); end_cycle(); end

        // Write port stalled with both writers pending, then released.
        do_reset();
        bus.m0_wr_vld_i = 1'b1; bus.m1_wr_vld_i = 1'b1;
        bus.m0_wr_addr_i = 8'h60; bus.m1_wr_addr_i = 8'h61;
        bus.m0_wr_data_i = 8'h01; bus.m1_wr_data_i = 8'h02;
        bus.mem_wr_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_wr_rdy", {bus.m0_wr_rdy_o, bus.m1_wr_rdy_o}, 2'b00);
            end_cycle();
        end
        bus.mem_wr_rdy_i = 1'b1;
        @(negedge clk);
        chk("stall_release_m0", {bus.m0_wr_rdy_o, bus.m1_wr_rdy_o}, 2'b10);
        end_cycle();
        idle_inputs();

        // Both requesters reading back-to-back for four cycles.
        do_reset();
        bus.m0_rd_vld_i = 1'b1; bus.m1_rd_vld_i = 1'b1;
        bus.m0_rd_addr_i = 8'h30; bus.m1_rd_addr_i = 8'h31;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (RR && (k % 2 == 1)) begin
                chk("b2b_grant", {bus.m0_rd_rdy_o, bus.m1_rd_rdy_o}, 2'b01);
                expect_read(1, 8'h31 ^ 8'hA5);
            end else begin
                chk("b2b_grant", {bus.m0_rd_rdy_o, bus.m1_rd_rdy_o}, 2'b10);
                expect_read(0, 8'h30 ^ 8'hA5);
            end
            end_cycle();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin @(negedge clk); end_cycle(); end

        // Same-cycle write and read of one address returns the old contents.
        mem[8'h20] = 8'h11;
        bus.m0_wr_vld_i = 1'b1; bus.m0_wr_addr_i = 8'h20; bus.m0_wr_data_i = 8'h55;
        bus.m1_rd_vld_i = 1'b1; bus.m1_rd_addr_i = 8'h20;
        @(negedge clk);
        chk("wr_rd_same_grants", {bus.m0_wr_rdy_o, bus.m1_rd_rdy_o}, 2'b11);
        expect_read(1, 8'h11);
        end_cycle();
        bus.m0_wr_vld_i = 1'b0;
        @(negedge clk);
        chk("rd_after_wr_grant", bus.m1_rd_rdy_o, 1'b1);
        expect_read(1, 8'h55);
        end_cycle();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin @(negedge clk); end_cycle(); end

        // Dropped response and a stray memory ready produce no pulse.
        bus.m0_rd_vld_i = 1'b1; bus.m0_rd_addr_i = 8'h40;
        @(negedge clk);
        chk("drop_grant", bus.m0_rd_rdy_o, 1'b1);
        expect_read(0, mem[8'h40]);
        drop_rsp = 1'b1;
        end_cycle();
        idle_inputs();
        @(negedge clk);
        stray_rdy = 1'b1;
        end_cycle();
        for (int i = 0; i < 3; i++) begin @(negedge clk); end_cycle(); end
        @(negedge clk);
        chk("rd_data_hold", bus.m0_rd_data_o, 8'h30 ^ 8'hA5);
        end_cycle();

        // Reset one cycle after a read is accepted discards it.
        bus.m0_rd_vld_i = 1'b1; bus.m0_rd_addr_i = 8'h41;
        @(negedge clk);
        chk("inflight_grant", bus.m0_rd_rdy_o, 1'b1);
        expect_read(0, mem[8'h41]);
        end_cycle();
        rst = 1'b1;
        bus.m1_rd_vld_i = 1'b1; bus.m0_wr_vld_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_rdy", {bus.m0_wr_rdy_o, bus.m1_wr_rdy_o, bus.m0_rd_rdy_o, bus.m1_rd_rdy_o}, 4'b0000);
        chk("rst_mid_mem_vld", {bus.mem_wr_vld_o, bus.mem_rd_vld_o}, 2'b00);
        end_cycle();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("rst_mid_data", {bus.m0_rd_data_o, bus.m1_rd_data_o}, 16'h0000);
        end_cycle();
        for (int i = 0; i < 3; i++) begin @(negedge clk); end_cycle(); end

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
